btn_pulse_conditioner: RTL and testbench

- Upstream front end for the two-button combination lock FSM.
- Takes two raw, asynchronous, bouncing push-button inputs.
- Produces clean, mutually exclusive, single-cycle press pulses on but_0/but_1; the lock FSM advances exactly one step per physical press.
- Also flags simultaneous-press conflicts.

---
 rtl/btn_pulse_conditioner.sv | 156 +++++++++++++++
 tb/tb_btn_pulse_conditioner.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_pulse_conditioner.sv
// btn_pulse_conditioner: two-button synchronizer, debouncer, press FSM and arbiter.
// Optional stuck-button detection is compiled in when BTN_STUCK_DETECT_EN is defined.
module btn_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int HOLD_LIMIT      = 1000,
  parameter int HOLD_W          = 10
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn0_raw,
  input  logic btn1_raw,
  output logic but_0,
  output logic but_1,
  output logic conflict,
  output logic STUCK
);

  typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} chan_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] req;
  logic [1:0] pressed;
  logic       stuck_now;

  assign raw = {btn1_raw, btn0_raw};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic             sync1_reg;
      logic             sync2_reg;
      logic             stable_reg;
      logic             req_reg;
      logic [CNT_W-1:0] cnt_reg;
      chan_state_t      state_reg;

      // The FSM moves on the same edge the debounced level flips, so the
      // request is registered one edge before the arbiter consumes it.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          stable_reg <= 1'b0;
          req_reg    <= 1'b0;
          cnt_reg    <= '0;
          state_reg  <= RELEASED;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          req_reg   <= 1'b0;
          if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
            case (state_reg)
              RELEASED: begin
                if (sync2_reg) begin
                  state_reg <= PRESSED;
                  req_reg   <= 1'b1;
                end
              end
              PRESSED: begin
                if (!sync2_reg) begin
                  state_reg <= RELEASED;
                end
              end
              default: state_reg <= RELEASED;
            endcase
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign req[gi]     = req_reg;
      assign pressed[gi] = (state_reg == PRESSED);
    end
  endgenerate

`ifdef BTN_STUCK_DETECT_EN
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LIMIT);

  logic [1:0] hold_full;
  logic       stuck_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hold
      logic [HOLD_W-1:0] hold_reg;
      logic [HOLD_W-1:0] hold_next;

      always_comb begin
        hold_next = hold_reg;
        if (!pressed[gi]) begin
          hold_next = '0;
        end else if (hold_reg != HOLD_MAX) begin
          hold_next = hold_reg + 1'b1;
        end
      end

      always_ff @(posedge CLK) begin
        if (RESET) begin
          hold_reg <= '0;
        end else begin
          hold_reg <= hold_next;
        end
      end

      assign hold_full[gi] = (hold_next == HOLD_MAX);
    end
  endgenerate

  // Counter clears one edge after release, so STUCK drops the edge after it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stuck_reg <= 1'b0;
    end else begin
      stuck_reg <= |hold_full;
    end
  end

  assign stuck_now = stuck_reg;
  assign STUCK     = stuck_reg;
`else
  logic [HOLD_W-1:0] unused_hold_cfg;
  assign unused_hold_cfg = HOLD_W'(HOLD_LIMIT);
  assign stuck_now       = 1'b0;
  assign STUCK           = 1'b0;
`endif

  // A request is honoured only while the other channel is released;
  // simultaneous requests become a conflict pulse instead.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      but_0    <= 1'b0;
      but_1    <= 1'b0;
      conflict <= 1'b0;
    end else begin
      but_0    <= 1'b0;
      but_1    <= 1'b0;
      conflict <= 1'b0;
      if (!stuck_now) begin
        if (req[0] && req[1]) begin
          conflict <= 1'b1;
        end else if (req[0] && !pressed[1]) begin
          but_0 <= 1'b1;
        end else if (req[1] && !pressed[0]) begin
          but_1 <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// Directed bench for btn_pulse_conditioner with DEBOUNCE_CYCLES=4 and HOLD_LIMIT=50.
module tb_btn_pulse_conditioner;

  localparam int DB = 4;
  localparam int LAT = DB + 3;  // input set after edge k -> pulse registered at edge k+LAT

  logic clk = 1'b0;
  logic RESET = 1'b1;
  logic btn0_raw = 1'b0;
  logic btn1_raw = 1'b0;
  logic but_0, but_1, conflict, STUCK;

  btn_pulse_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(5),
    .HOLD_LIMIT(50),
    .HOLD_W(10)
  ) dut (
    .CLK(clk),
    .RESET(RESET),
    .btn0_raw(btn0_raw),
    .btn1_raw(btn1_raw),
    .but_0(but_0),
    .but_1(but_1),
    .conflict(conflict),
    .STUCK(STUCK)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log: kind 0 = but_0, 1 = but_1, 2 = conflict; edge = index of registering edge.
  int ev_kind[$];
  int ev_edge[$];
  int overlap_cnt = 0;
  int rst_bad = 0;
  int stuck_cycles = 0;
  int stuck_rise = -1;
  int stuck_fall = -1;
  logic stuck_prev = 1'b0;

  always @(negedge clk) begin
    if (but_0) begin ev_kind.push_back(0); ev_edge.push_back(cyc); end
    if (but_1) begin ev_kind.push_back(1); ev_edge.push_back(cyc); end
    if (conflict) begin ev_kind.push_back(2); ev_edge.push_back(cyc); end
    if (but_0 && but_1) overlap_cnt++;
    if (RESET && (but_0 || but_1 || conflict || STUCK)) rst_bad++;
    if (STUCK) stuck_cycles++;
    if (STUCK && !stuck_prev) stuck_rise = cyc;
    if (!STUCK && stuck_prev) stuck_fall = cyc;
    stuck_prev = STUCK;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    ev_kind.delete();
    ev_edge.delete();
    overlap_cnt = 0;
    rst_bad = 0;
    stuck_cycles = 0;
    stuck_rise = -1;
    stuck_fall = -1;
  endtask

  function automatic int count_kind(input int k);
    int n = 0;
    foreach (ev_kind[i]) if (ev_kind[i] == k) n++;
    return n;
  endfunction

  // Returns the edge index at which reset was released (first free edge is +1).
  task automatic do_reset(input int n, output int base);
    RESET = 1'b1;
    repeat (n) step();
    RESET = 1'b0;
    base = cyc;
  endtask

  typedef struct {
    string name;
    int    s0, l0, s1, l1;   // start step and length of each raw press
    int    n0, n1, nc;       // expected pulse counts
    int    first;            // expected edge of first event relative to base, -1 = none
  } scn_t;

  scn_t scn[8];

  task automatic run_scn(input scn_t s);
    int base;
    btn0_raw = 1'b0;
    btn1_raw = 1'b0;
    clear_log();
    do_reset(3, base);
    check({s.name, "_reset_outputs"}, rst_bad, 0);
    for (int i = 0; i < 60; i++) begin
      btn0_raw = (i >= s.s0) && (i < s.s0 + s.l0);
      btn1_raw = (i >= s.s1) && (i < s.s1 + s.l1);
      step();
    end
    btn0_raw = 1'b0;
    btn1_raw = 1'b0;
    check({s.name, "_but0"}, count_kind(0), s.n0);
    check({s.name, "_but1"}, count_kind(1), s.n1);
    check({s.name, "_conflict"}, count_kind(2), s.nc);
    check({s.name, "_first_edge"}, (ev_edge.size() > 0) ? ev_edge[0] - base : -1, s.first);
    check({s.name, "_overlap"}, overlap_cnt, 0);
    check({s.name, "_stuck"}, stuck_cycles, 0);
    $display("scenario %s: events=%0d first=%0d", s.name, ev_kind.size(),
             (ev_edge.size() > 0) ? ev_edge[0] - base : -1);
  endtask

  initial begin
    int base;
    int k;
    int hist;
    int npress;
    int exp_seq[5];

    scn[0] = '{"press0",        2, 30, 0,  0,  1, 0, 0, 2 + LAT};
    scn[1] = '{"press1",        0,  0, 2, 30,  0, 1, 0, 2 + LAT};
    scn[2] = '{"both_same",     3, 30, 3, 30,  0, 0, 1, 3 + LAT};
    scn[3] = '{"hold0_then1",   2, 40, 12, 10, 1, 0, 0, 2 + LAT};
    scn[4] = '{"glitch_short",  2,  3, 0,  0,  0, 0, 0, -1};
    scn[5] = '{"glitch_exact",  2,  4, 0,  0,  1, 0, 0, 2 + LAT};
    scn[6] = '{"hold1_then0",   5, 40, 2, 40,  0, 1, 0, 2 + LAT};
    scn[7] = '{"one_cycle_lag", 2, 30, 3, 30,  1, 0, 0, 2 + LAT};

    for (int i = 0; i < 8; i++) run_scn(scn[i]);

    // Bounce on btn1: 1,0,1,0,1,0 then hold; final rise is set at step 6.
    clear_log();
    do_reset(3, base);
    for (int i = 0; i < 40; i++) begin
      btn1_raw = (i < 6) ? ((i % 2) == 0) : 1'b1;
      step();
    end
    btn1_raw = 1'b0;
    check("bounce_but1_count", count_kind(1), 1);
    check("bounce_event_count", ev_kind.size(), 1);
    check("bounce_edge", (ev_edge.size() > 0) ? ev_edge[0] - base : -1, 6 + LAT);
    $display("sequence bounce: events=%0d", ev_kind.size());

    // Reset while btn0 is held: exactly one fresh pulse after release of reset.
    clear_log();
    do_reset(3, base);
    btn0_raw = 1'b1;
    repeat (15) step();
    check("midreset_pre_pulse", count_kind(0), 1);
    clear_log();
    do_reset(3, base);
    repeat (20) step();
    btn0_raw = 1'b0;
    repeat (10) step();
    check("midreset_during_reset", rst_bad, 0);
    check("midreset_post_pulse", count_kind(0), 1);
    check("midreset_post_edge", (ev_edge.size() > 0) ? ev_edge[0] - base : -1, LAT);
    $display("sequence midreset: events=%0d", ev_kind.size());

    // Code 0,1,0,1,1 with 20-cycle gaps, fed to a small shift-register lock model.
    exp_seq = '{0, 1, 0, 1, 1};
    clear_log();
    do_reset(3, base);
    for (int i = 0; i < 150; i++) begin
      k = (i - 2) / 28;
      btn0_raw = (i >= 2) && (k < 5) && (((i - 2) % 28) < 8) && (exp_seq[k] == 0);
      btn1_raw = (i >= 2) && (k < 5) && (((i - 2) % 28) < 8) && (exp_seq[k] == 1);
      step();
    end
    btn0_raw = 1'b0;
    btn1_raw = 1'b0;
    check("seq_event_count", ev_kind.size(), 5);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("seq_kind_%0d", j), (j < ev_kind.size()) ? ev_kind[j] : -1, exp_seq[j]);
      check($sformatf("seq_edge_%0d", j), (j < ev_edge.size()) ? ev_edge[j] - base : -1,
            2 + 28 * j + LAT);
    end
    hist = 0;
    npress = 0;
    foreach (ev_kind[i]) begin
      if (ev_kind[i] < 2) begin
        hist = ((hist << 1) | ev_kind[i]) & 5'h1f;
        npress++;
      end
    end
    check("seq_unlock", (npress >= 5) && (hist == 5'b01011), 1);
    check("seq_overlap", overlap_cnt, 0);
    $display("sequence code: events=%0d unlock=%0d", ev_kind.size(),
             (npress >= 5) && (hist == 5'b01011));

`ifdef BTN_STUCK_DETECT_EN
    // Hold btn0 for 80 steps: PRESSED at base+6, hold hits 50 at base+56,
    // debounced release at base+86, STUCK drops at base+87.
    clear_log();
    do_reset(3, base);
    for (int i = 0; i < 110; i++) begin
      btn0_raw = (i < 80);
      btn1_raw = (i >= 65) && (i < 75);
      step();
    end
    btn0_raw = 1'b0;
    btn1_raw = 1'b0;
    check("stuck_rise_edge", stuck_rise - base, 56);
    check("stuck_fall_edge", stuck_fall - base, 87);
    check("stuck_but1_dropped", count_kind(1), 0);
    check("stuck_but0_count", count_kind(0), 1);
    $display("sequence stuck: rise=%0d fall=%0d", stuck_rise - base, stuck_fall - base);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
